// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul result path.
// Holds the serializer FSM states and the byte handshake phases.
package matmul_pkg;

  localparam int DATA_W = 16;
  localparam int MAX_N  = 8;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 7;

  localparam logic [7:0] CSUM_INIT = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    LATCH,
    SEND_HI,
    SEND_LO,
    CSUM,
    FIN
  } ser_state_e;

  typedef enum logic [1:0] {
    H_IDLE,
    H_GUARD,
    H_WAIT
  } hs_state_e;

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte uart_tx handshake: strobe, guard cycle, wait-not-busy.
// byte_done pulses once the transmitter is free again.
module tx_byte_handshake
  import matmul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic tx_busy,
  output logic tx_start,
  output logic byte_done
);

  hs_state_e ph, ph_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ph <= H_IDLE;
    else     ph <= ph_nxt;
  end

  always_comb begin
    ph_nxt    = ph;
    tx_start  = 1'b0;
    byte_done = 1'b0;
    unique case (ph)
      H_IDLE: begin
        if (req && !tx_busy) begin
          tx_start = 1'b1;
          ph_nxt   = H_GUARD;
        end
      end
      // busy may not have risen yet right after the strobe
      H_GUARD: ph_nxt = H_WAIT;
      H_WAIT: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          ph_nxt    = H_IDLE;
        end
      end
      default: ph_nxt = H_IDLE;
    endcase
  end

endmodule

// File: rtl/result_tx_serializer.sv
// Streams the N x N result matrix to uart_tx as a framed byte stream:
// size header, elements MSB first, XOR checksum.
module result_tx_serializer #(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int MAX_N  = matmul_pkg::MAX_N,
  parameter int ADDR_W = matmul_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              size_err
);

  import matmul_pkg::ser_state_e, matmul_pkg::CNT_W;
  import matmul_pkg::CSUM_INIT;
  import matmul_pkg::IDLE, matmul_pkg::HDR;
  import matmul_pkg::FETCH, matmul_pkg::LATCH;
  import matmul_pkg::SEND_HI, matmul_pkg::SEND_LO;
  import matmul_pkg::CSUM, matmul_pkg::FIN;

  ser_state_e state, state_nxt;

  logic [3:0]        n_q;
  logic [CNT_W-1:0]  nn_q;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        csum;
  logic [DATA_W-1:0] hold;
  logic              done_q;
  logic              size_err_q;

  logic [CNT_W-1:0] ms_w;
  logic [CNT_W-1:0] sq;
  logic             bad;
  logic             last;
  logic             req;
  logic             byte_done;

  assign ms_w = CNT_W'(matrix_size);
  assign sq   = ms_w * ms_w;
  assign bad  = (matrix_size == 4'd0) ||
                (int'(matrix_size) > MAX_N);
  assign last = (CNT_W'(addr) == nn_q - CNT_W'(1));

  assign req = (state == HDR) || (state == SEND_HI) ||
               (state == SEND_LO) || (state == CSUM);

  tx_byte_handshake u_hs (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .byte_done (byte_done)
  );

  always_comb begin
    tx_data = 8'h00;
    unique case (1'b1)
      (state == HDR):     tx_data = {4'h0, n_q};
      (state == SEND_HI): tx_data = hold[DATA_W-1 -: 8];
      (state == SEND_LO): tx_data = hold[7:0];
      (state == CSUM):    tx_data = csum;
      default:            tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !bad) state_nxt = HDR;
      HDR:     if (byte_done) state_nxt = FETCH;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = SEND_HI;
      SEND_HI: if (byte_done) state_nxt = SEND_LO;
      SEND_LO: if (byte_done) state_nxt = last ? CSUM : FETCH;
      CSUM:    if (byte_done) state_nxt = FIN;
      FIN:     if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      nn_q       <= '0;
      addr       <= '0;
      csum       <= CSUM_INIT;
      hold       <= '0;
      done_q     <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      size_err_q <= 1'b0;
      if (state == IDLE && start) begin
        if (bad) begin
          done_q     <= 1'b1;
          size_err_q <= 1'b1;
        end else begin
          n_q  <= matrix_size;
          nn_q <= sq;
          addr <= '0;
          csum <= CSUM_INIT;
        end
      end
      if (tx_start) csum <= csum ^ tx_data;
      if (state == LATCH) hold <= mem_rdata;
      if (state == SEND_LO && byte_done && !last)
        addr <= addr + ADDR_W'(1);
      if (state == FIN && !tx_busy) done_q <= 1'b1;
    end
  end

  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign size_err  = size_err_q;

endmodule

// File: tb/tb_result_tx_serializer.sv
// Directed bench for result_tx_serializer with RAM and uart_tx models.
// Checks frames against a byte-level model and hand-computed values.
module tb_result_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  matrix_size;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done;
  logic        size_err;

  logic        force_busy;
  int          bcnt = 0;
  logic [15:0] ram [64];

  logic [7:0]  bytes [$];
  int          addrs [$];
  int          done_cnt;
  int          err_cnt;
  bit          busy_seen;
  int          overlap = 0;
  int          dbl = 0;
  bit          prev_start = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          n;
    logic [15:0] base;
    int          len;
    bit          err;
    logic [7:0]  csum;
  } vec_t;

  vec_t vt [6];

  result_tx_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_size (matrix_size),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done),
    .size_err    (size_err)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy for 10 cycles starting the cycle after the strobe
  assign tx_busy = (bcnt != 0) || force_busy;

  always @(posedge clk) begin
    if (tx_start) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (tx_start) bytes.push_back(tx_data);
    if (mem_rd_en) addrs.push_back(int'(mem_addr));
    if (done) done_cnt++;
    if (size_err) err_cnt++;
    if (busy) busy_seen = 1'b1;
    if (tx_start && (done || size_err)) overlap++;
    if (tx_start && prev_start) dbl++;
    prev_start = tx_start;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    bytes.delete();
    addrs.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    busy_seen = 1'b0;
  endtask

  task automatic fill_ram(input logic [15:0] base);
    for (int k = 0; k < 64; k++) ram[k] = base + 16'(k);
  endtask

  task automatic send_start(input int n);
    @(negedge clk);
    start       = 1'b1;
    matrix_size = 4'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, int'(cyc >= limit), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input string name, input int k);
    int cyc;
    cyc = 0;
    while (bytes.size() < k && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_wait"}, int'(cyc >= 3000), 0);
  endtask

  task automatic check_frame(input int n, input string tag);
    logic [7:0] exp [$];
    logic [7:0] cs;
    int         bad;
    int         m;
    exp.push_back(8'(n));
    for (int k = 0; k < n * n; k++) begin
      exp.push_back(ram[k][15:8]);
      exp.push_back(ram[k][7:0]);
    end
    cs = 8'h00;
    foreach (exp[i]) cs ^= exp[i];
    exp.push_back(cs);
    chk({tag, "_len"}, bytes.size(), exp.size());
    m = (bytes.size() < exp.size()) ? bytes.size() : exp.size();
    bad = 0;
    for (int i = 0; i < m; i++)
      if (bytes[i] !== exp[i]) bad++;
    chk({tag, "_bytes"}, bad, 0);
    chk({tag, "_nrd"}, addrs.size(), n * n);
    bad = 0;
    foreach (addrs[i])
      if (addrs[i] != i) bad++;
    chk({tag, "_addr"}, bad, 0);
    chk({tag, "_done1"}, done_cnt, 1);
    chk({tag, "_busy0"}, int'(busy), 0);
  endtask

  function automatic int outs_or();
    return int'(tx_start | busy | done | size_err | mem_rd_en) |
           int'(|mem_addr) | int'(|tx_data);
  endfunction

  initial begin
    vt[0] = '{n: 1, base: 16'hABCD, len: 4,   err: 1'b0, csum: 8'h67};
    vt[1] = '{n: 3, base: 16'h0100, len: 20,  err: 1'b0, csum: 8'h0A};
    vt[2] = '{n: 0, base: 16'h0100, len: 0,   err: 1'b1, csum: 8'h00};
    vt[3] = '{n: 9, base: 16'h0100, len: 0,   err: 1'b1, csum: 8'h00};
    vt[4] = '{n: 2, base: 16'h0100, len: 10,  err: 1'b0, csum: 8'h02};
    vt[5] = '{n: 8, base: 16'h0100, len: 130, err: 1'b0, csum: 8'h08};

    rst         = 1'b1;
    start       = 1'b0;
    matrix_size = 4'd0;
    force_busy  = 1'b0;
    mem_rdata   = 16'h0000;
    fill_ram(16'h0000);
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_or(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vt[v]) begin
      fill_ram(vt[v].base);
      clear_mon();
      send_start(vt[v].n);
      if (vt[v].err) begin
        chk($sformatf("v%0d_done", v), int'(done), 1);
        chk($sformatf("v%0d_serr", v), int'(size_err), 1);
        repeat (20) @(negedge clk);
        chk($sformatf("v%0d_nobytes", v), bytes.size(), 0);
        chk($sformatf("v%0d_nobusy", v), int'(busy_seen), 0);
        chk($sformatf("v%0d_done1", v), done_cnt, 1);
      end else begin
        wait_done($sformatf("v%0d", v), 5000);
        check_frame(vt[v].n, $sformatf("v%0d", v));
        chk($sformatf("v%0d_tlen", v), bytes.size(), vt[v].len);
        if (bytes.size() > 0)
          chk($sformatf("v%0d_csum", v), int'(bytes[$]),
              int'(vt[v].csum));
        chk($sformatf("v%0d_noserr", v), err_cnt, 0);
      end
    end

    // uart held busy for 500 cycles right after the header
    fill_ram(16'h1234);
    clear_mon();
    send_start(2);
    wait_bytes("hold", 1);
    force_busy = 1'b1;
    repeat (500) @(negedge clk);
    chk("hold_no_tx", bytes.size(), 1);
    force_busy = 1'b0;
    wait_done("hold", 5000);
    check_frame(2, "hold");

    // second start mid-frame must be ignored
    fill_ram(16'h0100);
    clear_mon();
    send_start(3);
    wait_bytes("mid", 4);
    send_start(2);
    wait_done("mid", 5000);
    check_frame(3, "mid");
    chk("mid_csum", int'(bytes.size() > 0 ? bytes[$] : 8'hFF), 8'h0A);

    // asynchronous reset after byte 5 of an N=2 frame
    fill_ram(16'h0100);
    clear_mon();
    send_start(2);
    wait_bytes("rst", 5);
    rst = 1'b1;
    #1;
    chk("rst_outs", outs_or(), 0);
    repeat (5) @(negedge clk);
    chk("rst_hold_bytes", bytes.size(), 5);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("rst_after_bytes", bytes.size(), 5);
    chk("rst_no_done", done_cnt, 0);
    clear_mon();
    send_start(2);
    wait_done("rst2", 5000);
    check_frame(2, "rst2");

    chk("no_done_with_start", overlap, 0);
    chk("no_double_strobe", dbl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_tx_serializer.md
Name: result_tx_serializer

Overview:
- Streams the N x N product matrix from the result buffer to the host over the UART transmitter.
- Sends a framed byte stream: size header, each 16-bit element as two bytes (MSB first), then an XOR checksum byte.
- Sits between the result RAM (1-cycle read latency) and uart_tx (tx_start/tx_busy handshake).
- Driven by the top-level control FSM through start/done.

Parameters:
- DATA_W, 16, result element width; fixed at 16 (two bytes per element).
- MAX_N, 8, largest legal matrix dimension.
- ADDR_W, 6, result RAM address width; must satisfy 2**ADDR_W >= MAX_N*MAX_N.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to send a result; ignored unless idle
- matrix_size  in  4  N, sampled on the accepted start
- mem_rd_en  out  1  result RAM read strobe
- mem_addr  out  ADDR_W  result RAM address, row-major (i*N+j)
- mem_rdata  in  DATA_W  RAM data, valid the cycle after mem_rd_en
- tx_data  out  8  byte to transmit, stable while tx_start is high
- tx_start  out  1  one-cycle transmit strobe
- tx_busy  in  1  uart_tx busy; rises the cycle after tx_start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at the end of a frame or on a rejected start
- size_err  out  1  one-cycle pulse, coincident with done, on an illegal size

Behaviour:
- Reset: all outputs 0, FSM in IDLE, element counter, address and checksum cleared. Asynchronous reset mid-frame aborts immediately; no further tx_start is issued.
- Start acceptance: start is accepted only in IDLE.
  - If matrix_size is 0 or greater than MAX_N: pulse done and size_err the next cycle, stay IDLE, emit no bytes.
  - Otherwise latch N, set busy, clear checksum, go to HDR.
  - start while busy has no effect.
- Frame format: {N as 8-bit}, then elem[0].hi, elem[0].lo, ..., elem[N*N-1].lo, then csum. csum is the XOR of every preceding byte, header included.
- Total bytes per frame: 2 + 2*N*N (20 for N=3, 130 for N=8).
- States: IDLE, HDR, FETCH, LATCH, SEND_HI, SEND_LO, CSUM, FIN.
- Byte send rule, used by HDR, SEND_HI, SEND_LO and CSUM:
  - In the state with tx_busy=0, drive tx_data and pulse tx_start for exactly one cycle, and XOR the byte into csum.
  - Skip tx_busy for the one guard cycle after the strobe.
  - Then wait for tx_busy=0 before the next strobe.
  - tx_start is never high on two consecutive cycles.
- FETCH: assert mem_rd_en for one cycle at the current address.
- LATCH: capture mem_rdata into a 16-bit holding register.
- Transitions:
  - HDR -> FETCH.
  - FETCH -> LATCH -> SEND_HI -> SEND_LO.
  - SEND_LO -> FETCH with address+1 while address < N*N-1; otherwise SEND_LO -> CSUM.
  - CSUM -> FIN.
  - FIN waits for tx_busy=0, then pulses done, clears busy, and returns to IDLE.
- Arithmetic: compute N*N once at start into a 7-bit register. Address counter is ADDR_W bits and never exceeds N*N-1, so there is no wrap-around.
- mem_rd_en is high only in FETCH. mem_addr holds its value between fetches.
- done and size_err are never asserted together with tx_start.

Decomposition:
- Shared package (matmul_pkg): state enum for this FSM, MAX_N, DATA_W, and CSUM_INIT = 8'h00.
- Natural sub-module: tx_byte_handshake. It owns the strobe, guard cycle and wait-not-busy sequence, and returns a one-cycle byte_done. The serializer FSM instantiates it once.

Test Plan:
- N=1, RAM[0]=16'hABCD, tx_busy model 10 cycles per byte:
  - tx bytes 0x01, 0xAB, 0xCD, 0x67.
  - done pulses once, busy low afterwards.
- N=3, RAM[k]=16'h0100+k:
  - 20 bytes: 0x03, then 0x01,0x00 ... 0x01,0x08, then csum.
  - csum is the XOR of all prior bytes.
  - mem_addr is 0..8 in order, with exactly 9 mem_rd_en pulses.
- matrix_size=0 and matrix_size=9: done and size_err pulse one cycle later, zero tx_start, busy stays 0.
- tx_busy held high for 500 cycles after the header: no tx_start during that window; the frame resumes and completes correctly.
- Second start pulse mid-frame: ignored, and the frame is byte-identical to a clean run.
- rst asserted after byte 5 of an N=2 frame:
  - outputs go to 0 immediately, with no further tx_start.
  - a new start with N=2 produces a full correct 10-byte frame.
